// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions used by the BTB and the history predictor.
package bp_pkg;

  localparam logic [6:0] BR_OP = 7'b110_0011;
  localparam int unsigned SET_ADDR_LEN = 6;
  localparam int unsigned TAG_LEN = 32 - SET_ADDR_LEN - 2;

  typedef struct packed {
    logic               valid;
    logic [TAG_LEN-1:0] tag;
    logic [31:0]        target;
  } btb_entry_t;

endpackage

// File: rtl/btb_way.sv
// One BTB way: async-reset valid bits, tag/target storage, two combinational
// read ports (fetch lookup and EX-side hit check) and one write port.
module btb_way #(
  parameter int unsigned IdxLen = 6,
  parameter int unsigned TagLen = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IdxLen-1:0] rd_idx_a,
  output logic              rd_valid_a,
  output logic [TagLen-1:0] rd_tag_a,
  output logic [31:0]       rd_target_a,
  input  logic [IdxLen-1:0] rd_idx_b,
  output logic              rd_valid_b,
  output logic [TagLen-1:0] rd_tag_b,
  output logic [31:0]       rd_target_b,
  input  logic              we,
  input  logic [IdxLen-1:0] wr_idx,
  input  logic [TagLen-1:0] wr_tag,
  input  logic [31:0]       wr_target
);
  localparam int unsigned Sets = 1 << IdxLen;

  logic [Sets-1:0]   valid_q;
  logic [TagLen-1:0] tag_q    [Sets];
  logic [31:0]       target_q [Sets];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are only observed through a valid bit.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

  assign rd_valid_a  = valid_q[rd_idx_a];
  assign rd_tag_a    = tag_q[rd_idx_a];
  assign rd_target_a = target_q[rd_idx_a];
  assign rd_valid_b  = valid_q[rd_idx_b];
  assign rd_tag_b    = tag_q[rd_idx_b];
  assign rd_target_b = target_q[rd_idx_b];

endmodule

// File: rtl/btb.sv
// 2-way set-associative branch target buffer: IF lookup, EX update with
// LRU victim choice, mispredict/redirect generation and perf counters.
module btb #(
  parameter int unsigned SET_ADDR_LEN = bp_pkg::SET_ADDR_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC_IF,
  input  logic        PredictF,
  output logic        PredTakenF,
  output logic [31:0] NPC_Pred,
  input  logic [31:0] PC_EX,
  input  logic [6:0]  Opcode_EX,
  input  logic        br,
  input  logic [31:0] BrTarget_EX,
  input  logic        PredTaken_EX,
  input  logic [31:0] PredTarget_EX,
  input  logic        StallE,
  output logic        Mispredict_EX,
  output logic [31:0] Redirect_PC,
  output logic [31:0] BrCount,
  output logic [31:0] MissCount
);
  import bp_pkg::*;

  localparam int unsigned TagLen = 32 - SET_ADDR_LEN - 2;
  localparam int unsigned Sets   = 1 << SET_ADDR_LEN;

  logic [SET_ADDR_LEN-1:0] idx_f, idx_e;
  logic [TagLen-1:0]       tag_f, tag_e;
  logic [1:0]              v_f, v_e, hit_f, hit_e, way_we;
  logic [TagLen-1:0]       t_f [2];
  logic [TagLen-1:0]       t_e [2];
  logic [31:0]             tg_f [2];
  logic [31:0]             tg_e [2];
  logic                    is_br, upd, tbl_we, wr_way;
  logic [Sets-1:0]         lru_q;
  logic [31:0]             br_count_q, miss_count_q;

  assign idx_f = PC_IF[SET_ADDR_LEN+1:2];
  assign tag_f = PC_IF[31:SET_ADDR_LEN+2];
  assign idx_e = PC_EX[SET_ADDR_LEN+1:2];
  assign tag_e = PC_EX[31:SET_ADDR_LEN+2];

  for (genvar w = 0; w < 2; w++) begin : g_way
    btb_way #(
      .IdxLen(SET_ADDR_LEN),
      .TagLen(TagLen)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_a    (idx_f),
      .rd_valid_a  (v_f[w]),
      .rd_tag_a    (t_f[w]),
      .rd_target_a (tg_f[w]),
      .rd_idx_b    (idx_e),
      .rd_valid_b  (v_e[w]),
      .rd_tag_b    (t_e[w]),
      .rd_target_b (tg_e[w]),
      .we          (way_we[w]),
      .wr_idx      (idx_e),
      .wr_tag      (tag_e),
      .wr_target   (BrTarget_EX)
    );
    assign hit_f[w] = v_f[w] && (t_f[w] == tag_f);
    assign hit_e[w] = v_e[w] && (t_e[w] == tag_e);
  end

  assign PredTakenF = (|hit_f) && PredictF;
  assign NPC_Pred   = PredTakenF ? (hit_f[1] ? tg_f[1] : tg_f[0]) : PC_IF + 32'd4;

  assign is_br  = (Opcode_EX == BR_OP);
  assign upd    = is_br && !StallE;
  assign tbl_we = upd && br;

  // A hit rewrites in place; otherwise fill invalid ways first, then the LRU way.
  always_comb begin
    wr_way = 1'b0;
    if (hit_e[0])      wr_way = 1'b0;
    else if (hit_e[1]) wr_way = 1'b1;
    else if (!v_e[0])  wr_way = 1'b0;
    else if (!v_e[1])  wr_way = 1'b1;
    else               wr_way = lru_q[idx_e];
  end

  assign way_we = {tbl_we && wr_way, tbl_we && !wr_way};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru_q <= '0;
    end else if (tbl_we) begin
      lru_q[idx_e] <= ~wr_way;
    end
  end

  assign Mispredict_EX = is_br && ((br != PredTaken_EX) ||
                                   (br && PredTaken_EX && (PredTarget_EX != BrTarget_EX)));
  assign Redirect_PC   = br ? BrTarget_EX : PC_EX + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else if (upd) begin
      if (br_count_q != '1) br_count_q <= br_count_q + 32'd1;
      if (Mispredict_EX && (miss_count_q != '1)) miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign BrCount   = br_count_q;
  assign MissCount = miss_count_q;

endmodule
